// File: rtl/ldpc_pkg.sv
// Shared state type and latency defaults for the LDPC check-node scheduler.
package ldpc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    localparam int MEM_LAT_DEF = 1;
    localparam int MS_LAT_DEF  = 5;

endpackage

// File: rtl/ldpc_sched_delay.sv
// Fixed-depth shift register carrying {valid, row} alongside a row's trip
// through LLR memory and the min-sign unit. All stages are exposed as taps.
module ldpc_sched_delay #(
    parameter int DEPTH = 7,
    parameter int WIDTH = 9
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [WIDTH-1:0]       i_data,
    output logic [DEPTH*WIDTH-1:0] o_pipe
);

    logic [DEPTH*WIDTH-1:0] pipe_d;
    logic [DEPTH*WIDTH-1:0] pipe_q;

    // Stage k holds what entered k+1 cycles ago.
    always_comb begin
        pipe_d = pipe_q;
        pipe_d[WIDTH-1:0] = i_data;
        for (int k = 1; k < DEPTH; k++) begin
            pipe_d[k*WIDTH +: WIDTH] = pipe_q[(k-1)*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_pipe = pipe_q;

endmodule

// File: rtl/ldpc_cn_scheduler.sv
// Row-issue scheduler for a layered LDPC check-node unit.
// Build option: LDPC_CN_SCHED_EARLY_STOP_EN lets i_syndrome_ok end decoding early.
//
// state | meaning
// IDLE  | waiting for i_start
// ISSUE | reading one row per cycle unless i_hold
// DRAIN | last row issued, waiting for in-flight rows to write back
// CHECK | iteration done, decide stop or next iteration
// DONE  | o_done pulse, then back to IDLE
module ldpc_cn_scheduler
    import ldpc_pkg::*;
#(
    parameter int ROW_AW  = 8,
    parameter int ITER_W  = 6,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int MS_LAT  = MS_LAT_DEF
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ROW_AW-1:0] i_num_rows,
    input  logic [ITER_W-1:0] i_max_iter,
    input  logic              i_hold,
    input  logic              i_syndrome_ok,
    output logic              o_rd_en,
    output logic [ROW_AW-1:0] o_rd_addr,
    output logic              o_ms_latch,
    output logic              o_wr_en,
    output logic [ROW_AW-1:0] o_wr_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic [ITER_W-1:0] o_iter_count
);

    localparam int DEPTH = MEM_LAT + MS_LAT + 1;
    localparam int W     = ROW_AW + 1;

    sched_state_e      state_q,    state_d;
    logic [ROW_AW-1:0] num_rows_q, num_rows_d;
    logic [ITER_W-1:0] max_iter_q, max_iter_d;
    logic [ROW_AW-1:0] row_q,      row_d;
    logic [ITER_W-1:0] iter_q,     iter_d;
    logic              rd_en_q,    rd_en_d;
    logic [ROW_AW-1:0] rd_addr_q,  rd_addr_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic [DEPTH*W-1:0] pipe;
    logic               in_flight;
    logic               early_stop;
    logic               unused_pipe;

`ifdef LDPC_CN_SCHED_EARLY_STOP_EN
    assign early_stop = i_syndrome_ok;
`else
    logic unused_syndrome;
    assign unused_syndrome = i_syndrome_ok;
    assign early_stop      = 1'b0;
`endif

    ldpc_sched_delay #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_delay (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  ({rd_en_q, rd_addr_q}),
        .o_pipe  (pipe)
    );

    // A row counts as in flight from its read strobe until its write-back.
    always_comb begin
        in_flight = rd_en_q;
        for (int k = 0; k < DEPTH; k++) begin
            in_flight = in_flight | pipe[k*W + ROW_AW];
        end
    end

    assign unused_pipe = ^pipe;

    always_comb begin
        state_d    = state_q;
        num_rows_d = num_rows_q;
        max_iter_d = max_iter_q;
        row_d      = row_q;
        iter_d     = iter_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    num_rows_d = i_num_rows;
                    max_iter_d = (i_max_iter == '0) ? ITER_W'(1) : i_max_iter;
                    iter_d     = '0;
                    row_d      = '0;
                    state_d    = (i_num_rows == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!i_hold) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = row_q;
                    row_d     = row_q + ROW_AW'(1);
                    if (row_q == num_rows_q - ROW_AW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!in_flight) begin
                    iter_d  = iter_q + ITER_W'(1);
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (iter_q == max_iter_q || early_stop) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs follow the state being entered so they line up with it.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            num_rows_q <= '0;
            max_iter_q <= '0;
            row_q      <= '0;
            iter_q     <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            max_iter_q <= max_iter_d;
            row_q      <= row_d;
            iter_q     <= iter_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign o_rd_en      = rd_en_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_ms_latch   = pipe[(MEM_LAT-1)*W + ROW_AW];
    assign o_wr_en      = pipe[(DEPTH-1)*W + ROW_AW];
    assign o_wr_addr    = pipe[(DEPTH-1)*W +: ROW_AW];
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_iter_count = iter_q;

endmodule

// File: doc/ldpc_cn_scheduler.md
LDPC_CN_SCHEDULER -- requirements
Module: ldpc_cn_scheduler

Interface
REQ-001 SHALL have parameter ROW_AW, default 8, width of the row index.
REQ-002 SHALL have parameter ITER_W, default 6, width of the iteration count.
REQ-003 SHALL have parameter MEM_LAT, default 1, cycles from o_rd_en to the row data being valid at the min-sign unit inputs.
REQ-004 SHALL have parameter MS_LAT, default 5, cycles from the latch pulse to the min-sign unit output being valid.
REQ-005 SHALL have port i_clock, input, 1, clock.
REQ-006 SHALL have port i_reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_start, input, 1, begin a decode.
REQ-008 SHALL have port i_num_rows, input, ROW_AW, rows per iteration.
REQ-009 SHALL have port i_max_iter, input, ITER_W, iteration limit.
REQ-010 SHALL have port i_hold, input, 1, pause row issue.
REQ-011 SHALL have port i_syndrome_ok, input, 1, parity satisfied.
REQ-012 SHALL have port o_rd_en, output, 1, LLR memory read strobe.
REQ-013 SHALL have port o_rd_addr, output, ROW_AW, read row.
REQ-014 SHALL have port o_ms_latch, output, 1, min-sign input latch pulse.
REQ-015 SHALL have port o_wr_en, output, 1, write-back strobe.
REQ-016 SHALL have port o_wr_addr, output, ROW_AW, write-back row.
REQ-017 SHALL have port o_busy, output, 1, decode in progress.
REQ-018 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-019 SHALL have port o_iter_count, output, ITER_W, iterations completed.

Function
REQ-020 SHALL implement states IDLE, ISSUE, DRAIN, CHECK, DONE.
REQ-021 SHALL leave IDLE on i_start, sample i_num_rows/i_max_iter into registers, clear o_iter_count, and enter ISSUE; an i_start seen outside IDLE SHALL be ignored.
REQ-022 SHALL treat a sampled i_max_iter of 0 as 1.
REQ-023 SHALL, on a sampled i_num_rows of 0, go directly to DONE with o_iter_count=0.
REQ-024 SHALL, in ISSUE with i_hold low, assert o_rd_en and present row r on o_rd_addr, with r running 0..num_rows-1 and one row per cycle.
REQ-025 SHALL, while i_hold is high, deassert o_rd_en and freeze r; rows already in flight SHALL continue.
REQ-026 SHALL assert o_ms_latch exactly MEM_LAT cycles after each o_rd_en.
REQ-027 SHALL assert o_wr_en with o_wr_addr equal to the issued row exactly MEM_LAT+MS_LAT+1 cycles after each o_rd_en.
REQ-028 SHALL track the timing of REQ-026/REQ-027 with a valid+address delay line of depth MEM_LAT+MS_LAT+1.
REQ-029 SHALL enter DRAIN after issuing row num_rows-1.
REQ-030 SHALL leave DRAIN for CHECK when the delay line is empty, and SHALL increment o_iter_count on that transition.
REQ-031 SHALL, in CHECK, go to DONE if o_iter_count equals max_iter (or on the early-stop condition of REQ-037); otherwise it SHALL reset r to 0 and re-enter ISSUE.
REQ-032 SHALL, in DONE, pulse o_done for one cycle and return to IDLE.
REQ-033 SHALL hold o_busy high in every state except IDLE.
REQ-034 SHALL keep o_iter_count valid and stable from DONE until the next accepted i_start.

Reset
REQ-035 SHALL, on i_reset, return to IDLE, clear the delay line, drop in-flight rows, and force o_rd_en, o_ms_latch, o_wr_en, o_busy, o_done, o_rd_addr, o_wr_addr and o_iter_count to 0; this SHALL also hold for a reset asserted mid-decode.

Configuration
REQ-036 SHALL use macro LDPC_CN_SCHED_EARLY_STOP_EN.
REQ-037 SHALL, with the macro defined, treat i_syndrome_ok high in CHECK as a condition for DONE.
REQ-038 SHALL, without the macro, ignore i_syndrome_ok and always run max_iter iterations; the port SHALL still be present.

Structure
REQ-039 SHALL place the state enum typedef and the MEM_LAT/MS_LAT defaults in package ldpc_pkg.
REQ-040 SHALL implement the delay line as sub-module ldpc_sched_delay (parameters DEPTH, WIDTH).

Verification
REQ-041 SHALL cover: num_rows=4, max_iter=2, defaults -> reads 0,1,2,3 twice; o_ms_latch at read+1; o_wr_en at read+7; o_done with o_iter_count=2.
REQ-042 SHALL cover: i_hold high 3 cycles after row 1 -> 3-cycle gap in reads and writes, row order kept, no rows lost.
REQ-043 SHALL cover: EARLY_STOP_EN defined, max_iter=5, i_syndrome_ok high in the 2nd CHECK -> o_done with o_iter_count=2; without the macro -> o_iter_count=5.
REQ-044 SHALL cover: i_num_rows=0 -> o_done within 3 cycles, o_iter_count=0, no o_rd_en.
REQ-045 SHALL cover: i_reset during the 2nd row -> all outputs 0 the next cycle, no o_wr_en afterwards, and a new i_start runs cleanly.
REQ-046 SHALL cover: i_start pulsed while o_busy is high -> ignored, decode completes unchanged.
